// File: rtl/i2c_reg_master.sv
// i2c_reg_master: one-register I2C write/read master (open-drain pads).
// Define I2C_MASTER_CLK_STRETCH_EN to honour slave clock stretching.
module i2c_reg_master #(
  parameter int         CLK_DIV  = 4,
  parameter logic [6:0] DEV_ADDR = 7'h3c
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] dataIn,
  input  logic       writeEn,
  input  logic       readEn,
  output logic       busy,
  output logic       done,
  output logic       ackErr,
  output logic [7:0] dataOut,
  output logic       sclOut,
  output logic       sdaOut,
  input  logic       sdaIn,
  input  logic       sclIn
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] SEND_BYTE = 3'd2;
  localparam logic [2:0] GET_ACK   = 3'd3;
  localparam logic [2:0] RSTART    = 3'd4;
  localparam logic [2:0] RECV_BYTE = 3'd5;
  localparam logic [2:0] SEND_NACK = 3'd6;
  localparam logic [2:0] STOP      = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    phase_q, phase_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          ackerr_q, ackerr_d;
  logic [7:0]    dout_q, dout_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;

  logic hold;
  logic q_end;
  logic sample;
  logic slot_end;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // SCL released in q2 but still held low by the target: freeze time.
  assign hold = (state_q != IDLE) && (quarter_q == 2'd2) && !sclIn;
`else
  logic unused_scl_in;
  assign unused_scl_in = sclIn;
  assign hold = 1'b0;
`endif

  assign q_end    = (qcnt_q == QLAST);
  assign sample   = q_end && (quarter_q == 2'd2) && !hold;
  assign slot_end = q_end && (quarter_q == 2'd3);

  // Next-state: quarter timing, bit/byte sequencing and result capture.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    rd_d      = rd_q;
    err_d     = err_q;
    shreg_d   = shreg_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    ackerr_d  = ackerr_q;
    dout_d    = dout_q;

    if (state_q != IDLE && !hold) begin
      if (q_end) begin
        qcnt_d    = '0;
        quarter_d = quarter_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (writeEn || readEn) begin
          state_d   = START;
          rd_d      = !writeEn;
          reg_d     = addr;
          wdata_d   = dataIn;
          err_d     = 1'b0;
          ackerr_d  = 1'b0;
          phase_d   = 2'd0;
          qcnt_d    = '0;
          quarter_d = 2'd0;
        end
      end
      START: begin
        if (slot_end) begin
          state_d = SEND_BYTE;
          shreg_d = {DEV_ADDR, 1'b0};
          bit_d   = 3'd7;
        end
      end
      SEND_BYTE: begin
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            state_d = GET_ACK;
          end else begin
            bit_d   = bit_q - 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
          end
        end
      end
      GET_ACK: begin
        if (sample && sdaIn) begin
          err_d = 1'b1;
        end
        if (slot_end) begin
          bit_d = 3'd7;
          if (err_q) begin
            state_d = STOP;
          end else begin
            unique case (phase_q)
              2'd0: begin
                state_d = SEND_BYTE;
                shreg_d = reg_q;
                phase_d = 2'd1;
              end
              2'd1: begin
                state_d = rd_q ? RSTART : SEND_BYTE;
                shreg_d = wdata_q;
                phase_d = 2'd2;
              end
              default: begin
                state_d = rd_q ? RECV_BYTE : STOP;
              end
            endcase
          end
        end
      end
      RSTART: begin
        if (slot_end) begin
          state_d = SEND_BYTE;
          shreg_d = {DEV_ADDR, 1'b1};
          bit_d   = 3'd7;
        end
      end
      RECV_BYTE: begin
        if (sample) begin
          shreg_d = {shreg_q[6:0], sdaIn};
        end
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            state_d = SEND_NACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      SEND_NACK: begin
        if (slot_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (slot_end) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          ackerr_d = err_q;
          if (rd_q && !err_q) begin
            dout_d = shreg_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pad levels for the coming cycle, derived from the next state/quarter.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    unique case (state_d)
      IDLE: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
      START, RSTART: begin
        scl_d = (quarter_d != 2'd0);
        sda_d = !quarter_d[1];
      end
      SEND_BYTE: begin
        scl_d = quarter_d[1];
        sda_d = shreg_d[7];
      end
      STOP: begin
        scl_d = (quarter_d != 2'd0);
        sda_d = quarter_d[1];
      end
      default: begin
        scl_d = quarter_d[1];
        sda_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      qcnt_q    <= '0;
      quarter_q <= 2'd0;
      bit_q     <= 3'd7;
      phase_q   <= 2'd0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      shreg_q   <= 8'h00;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      done_q    <= 1'b0;
      ackerr_q  <= 1'b0;
      dout_q    <= 8'h00;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      shreg_q   <= shreg_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      ackerr_q  <= ackerr_d;
      dout_q    <= dout_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign ackErr  = ackerr_q;
  assign dataOut = dout_q;
  assign sclOut  = scl_q;
  assign sdaOut  = sda_q;

endmodule

// File: tb/tb_i2c_reg_master.sv
// tb_i2c_reg_master: directed bench with a behavioural I2C target
// on the open-drain bus.
module tb_i2c_reg_master;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  localparam int STRETCH = 10;
`else
  localparam int STRETCH = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [7:0] dataIn = 8'h00;
  logic       writeEn = 1'b0;
  logic       readEn = 1'b0;
  logic       busy, done, ackErr;
  logic [7:0] dataOut;
  logic       sclOut, sdaOut;
  logic       sdaIn, sclIn;

  logic       stretch = 1'b0;
  logic       slave_sda = 1'b1;
  logic       present = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       scl_bus, sda_bus;

  assign scl_bus = sclOut & ~stretch;
  assign sda_bus = sdaOut & slave_sda;
  assign sdaIn   = sda_bus;
  assign sclIn   = scl_bus;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2c_reg_master #(.CLK_DIV(4), .DEV_ADDR(7'h3c)) dut (
    .clk(clk), .rst(rst), .addr(addr), .dataIn(dataIn),
    .writeEn(writeEn), .readEn(readEn), .busy(busy),
    .done(done), .ackErr(ackErr), .dataOut(dataOut),
    .sclOut(sclOut), .sdaOut(sdaOut), .sdaIn(sdaIn), .sclIn(sclIn)
  );

  // Behavioural target, sampled mid-cycle.
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         bitc = 0;
  logic [7:0] sr = 8'h00, txsr = 8'h00;
  logic       ackslot = 1'b0, tx = 1'b0, tx_pend = 1'b0;
  logic       first = 1'b0, active = 1'b0, mnack = 1'b0;
  logic [7:0] log_b [0:63];
  int         nlog = 0, nstart = 0, nstop = 0;
  logic       addr_ok;
  assign addr_ok = present && (sr[7:1] == 7'h3c);

  always @(negedge clk) begin
    if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
      nstart <= nstart + 1;
      bitc <= 0; ackslot <= 1'b0; tx <= 1'b0; tx_pend <= 1'b0;
      first <= 1'b1; active <= 1'b1; slave_sda <= 1'b1;
    end else if (prev_scl && scl_bus && !prev_sda && sda_bus) begin
      nstop <= nstop + 1;
      bitc <= 0; ackslot <= 1'b0; tx <= 1'b0;
      active <= 1'b0; slave_sda <= 1'b1;
    end else if (!prev_scl && scl_bus) begin
      if (ackslot) begin
        if (tx) mnack <= sda_bus;
      end else if (bitc < 8) begin
        if (!tx) sr <= {sr[6:0], sda_bus};
        bitc <= bitc + 1;
      end
    end else if (prev_scl && !scl_bus) begin
      if (ackslot) begin
        ackslot <= 1'b0;
        bitc <= 0;
        if (tx) begin
          tx <= 1'b0;
          slave_sda <= 1'b1;
        end else if (tx_pend) begin
          tx <= 1'b1;
          tx_pend <= 1'b0;
          slave_sda <= rdata[7];
          txsr <= {rdata[6:0], 1'b0};
        end else begin
          slave_sda <= 1'b1;
        end
      end else if (bitc == 8) begin
        ackslot <= 1'b1;
        if (tx) begin
          slave_sda <= 1'b1;
        end else begin
          if (nlog < 64) begin
            log_b[nlog] <= sr;
            nlog <= nlog + 1;
          end
          if (first) begin
            first <= 1'b0;
            active <= addr_ok;
            tx_pend <= addr_ok && sr[0];
            slave_sda <= !addr_ok;
          end else begin
            slave_sda <= !active;
          end
        end
      end else if (tx) begin
        slave_sda <= txsr[7];
        txsr <= {txsr[6:0], 1'b0};
      end
    end
    prev_scl <= scl_bus;
    prev_sda <= sda_bus;
  end

  // Issue one request from #1 after an edge; return done latency.
  task automatic do_req(input logic w, input logic r,
                        input logic [7:0] a, input logic [7:0] d,
                        output int lat, output logic b1);
    addr = a; dataIn = d; writeEn = w; readEn = r;
    @(posedge clk); #1;
    writeEn = 1'b0; readEn = 1'b0;
    b1 = busy;
    lat = -1;
    for (int i = 1; i <= 3000 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    n_checks++; if (ackErr !== 1'b0) begin n_fail++; $display("FAIL rst_ackerr got %b want 0", ackErr); end
    n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL rst_dout got %h want 00", dataOut); end
    n_checks++; if (sclOut !== 1'b1) begin n_fail++; $display("FAIL rst_scl got %b want 1", sclOut); end
    n_checks++; if (sdaOut !== 1'b1) begin n_fail++; $display("FAIL rst_sda got %b want 1", sdaOut); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int lat, b, s0, p0;
    logic b1;
    b = nlog; s0 = nstart; p0 = nstop;
    do_req(1'b1, 1'b0, 8'h02, 8'hA5, lat, b1);
    repeat (4) @(posedge clk); #1;
    n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL wr_busy got %b want 1", b1); end
    n_checks++; if (lat != 464) begin n_fail++; $display("FAIL wr_latency got %0d want 464", lat); end
    n_checks++; if (ackErr !== 1'b0) begin n_fail++; $display("FAIL wr_ackerr got %b want 0", ackErr); end
    n_checks++; if (nlog - b != 3) begin n_fail++; $display("FAIL wr_nbytes got %0d want 3", nlog - b); end
    n_checks++; if (log_b[b] !== 8'h78) begin n_fail++; $display("FAIL wr_byte0 got %h want 78", log_b[b]); end
    n_checks++; if (log_b[b+1] !== 8'h02) begin n_fail++; $display("FAIL wr_byte1 got %h want 02", log_b[b+1]); end
    n_checks++; if (log_b[b+2] !== 8'hA5) begin n_fail++; $display("FAIL wr_byte2 got %h want a5", log_b[b+2]); end
    n_checks++; if (nstart - s0 != 1) begin n_fail++; $display("FAIL wr_starts got %0d want 1", nstart - s0); end
    n_checks++; if (nstop - p0 != 1) begin n_fail++; $display("FAIL wr_stops got %0d want 1", nstop - p0); end
    n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL wr_dout got %h want 00", dataOut); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle got %b want 0", busy); end
  endtask

  task automatic test_read();
    int lat, b, s0, p0;
    logic b1;
    present = 1'b1; rdata = 8'h5A;
    b = nlog; s0 = nstart; p0 = nstop;
    do_req(1'b0, 1'b1, 8'h05, 8'h00, lat, b1);
    n_checks++; if (dataOut !== 8'h5A) begin n_fail++; $display("FAIL rd_dout got %h want 5a", dataOut); end
    n_checks++; if (lat != 624) begin n_fail++; $display("FAIL rd_latency got %0d want 624", lat); end
    repeat (4) @(posedge clk); #1;
    n_checks++; if (ackErr !== 1'b0) begin n_fail++; $display("FAIL rd_ackerr got %b want 0", ackErr); end
    n_checks++; if (nlog - b != 3) begin n_fail++; $display("FAIL rd_nbytes got %0d want 3", nlog - b); end
    n_checks++; if (log_b[b] !== 8'h78) begin n_fail++; $display("FAIL rd_byte0 got %h want 78", log_b[b]); end
    n_checks++; if (log_b[b+1] !== 8'h05) begin n_fail++; $display("FAIL rd_byte1 got %h want 05", log_b[b+1]); end
    n_checks++; if (log_b[b+2] !== 8'h79) begin n_fail++; $display("FAIL rd_byte2 got %h want 79", log_b[b+2]); end
    n_checks++; if (nstart - s0 != 2) begin n_fail++; $display("FAIL rd_starts got %0d want 2", nstart - s0); end
    n_checks++; if (nstop - p0 != 1) begin n_fail++; $display("FAIL rd_stops got %0d want 1", nstop - p0); end
    n_checks++; if (mnack !== 1'b1) begin n_fail++; $display("FAIL rd_master_nack got %b want 1", mnack); end
  endtask

  task automatic test_addr_nack();
    int lat, b, p0;
    logic b1;
    present = 1'b0;
    b = nlog; p0 = nstop;
    do_req(1'b1, 1'b0, 8'h02, 8'h11, lat, b1);
    n_checks++; if (lat != 176) begin n_fail++; $display("FAIL nack_latency got %0d want 176", lat); end
    n_checks++; if (ackErr !== 1'b1) begin n_fail++; $display("FAIL nack_ackerr got %b want 1", ackErr); end
    repeat (6) @(posedge clk); #1;
    n_checks++; if (ackErr !== 1'b1) begin n_fail++; $display("FAIL nack_ackerr_hold got %b want 1", ackErr); end
    n_checks++; if (dataOut !== 8'h5A) begin n_fail++; $display("FAIL nack_dout got %h want 5a", dataOut); end
    n_checks++; if (nlog - b != 1) begin n_fail++; $display("FAIL nack_nbytes got %0d want 1", nlog - b); end
    n_checks++; if (nstop - p0 != 1) begin n_fail++; $display("FAIL nack_stops got %0d want 1", nstop - p0); end
    present = 1'b1;
  endtask

  task automatic test_both_and_ignore();
    int lat, nd, b, s0;
    b = nlog; s0 = nstart;
    addr = 8'h11; dataIn = 8'h22; writeEn = 1'b1; readEn = 1'b1;
    @(posedge clk); #1;
    writeEn = 1'b0; readEn = 1'b0;
    lat = -1; nd = 0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (lat < 0) lat = i;
      end
      readEn = (i == 100);
    end
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL both_ndone got %0d want 1", nd); end
    n_checks++; if (lat != 464) begin n_fail++; $display("FAIL both_latency got %0d want 464", lat); end
    n_checks++; if (nstart - s0 != 1) begin n_fail++; $display("FAIL both_starts got %0d want 1", nstart - s0); end
    n_checks++; if (nlog - b != 3) begin n_fail++; $display("FAIL both_nbytes got %0d want 3", nlog - b); end
    n_checks++; if (log_b[b+1] !== 8'h11) begin n_fail++; $display("FAIL both_byte1 got %h want 11", log_b[b+1]); end
    n_checks++; if (log_b[b+2] !== 8'h22) begin n_fail++; $display("FAIL both_byte2 got %h want 22", log_b[b+2]); end
    n_checks++; if (ackErr !== 1'b0) begin n_fail++; $display("FAIL both_ackerr got %b want 0", ackErr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_idle got %b want 0", busy); end
  endtask

  task automatic test_rst_mid();
    int lat, b;
    logic b1;
    addr = 8'h33; dataIn = 8'h44; writeEn = 1'b1;
    @(posedge clk); #1;
    writeEn = 1'b0;
    repeat (208) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (sclOut !== 1'b1) begin n_fail++; $display("FAIL rmid_scl got %b want 1", sclOut); end
    n_checks++; if (sdaOut !== 1'b1) begin n_fail++; $display("FAIL rmid_sda got %b want 1", sdaOut); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    b = nlog;
    do_req(1'b1, 1'b0, 8'h07, 8'h3C, lat, b1);
    n_checks++; if (lat != 464) begin n_fail++; $display("FAIL rmid_latency got %0d want 464", lat); end
    n_checks++; if (nlog - b != 3) begin n_fail++; $display("FAIL rmid_nbytes got %0d want 3", nlog - b); end
    n_checks++; if (log_b[b+1] !== 8'h07) begin n_fail++; $display("FAIL rmid_byte1 got %h want 07", log_b[b+1]); end
    n_checks++; if (log_b[b+2] !== 8'h3C) begin n_fail++; $display("FAIL rmid_byte2 got %h want 3c", log_b[b+2]); end
  endtask

  task automatic test_stretch();
    int lat, b, rises, sc;
    logic prev;
    b = nlog; rises = 0; sc = 0;
    addr = 8'h02; dataIn = 8'hA5; writeEn = 1'b1;
    @(posedge clk); #1;
    writeEn = 1'b0;
    prev = sclOut;
    lat = -1;
    for (int i = 1; i <= 3000 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (sc > 0) begin
        sc--;
        if (sc == 0) stretch = 1'b0;
      end
      if (!prev && sclOut) begin
        rises++;
        if (rises == 10 && STRETCH > 0) begin
          stretch = 1'b1;
          sc = STRETCH;
        end
      end
      prev = sclOut;
      if (done) lat = i;
    end
    stretch = 1'b0;
    n_checks++; if (lat != 464 + STRETCH) begin n_fail++; $display("FAIL str_latency got %0d want %0d", lat, 464 + STRETCH); end
    n_checks++; if (nlog - b != 3) begin n_fail++; $display("FAIL str_nbytes got %0d want 3", nlog - b); end
    n_checks++; if (log_b[b] !== 8'h78) begin n_fail++; $display("FAIL str_byte0 got %h want 78", log_b[b]); end
    n_checks++; if (log_b[b+2] !== 8'hA5) begin n_fail++; $display("FAIL str_byte2 got %h want a5", log_b[b+2]); end
    n_checks++; if (ackErr !== 1'b0) begin n_fail++; $display("FAIL str_ackerr got %b want 0", ackErr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_both_and_ignore();
    test_rst_mid();
    test_stretch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_master.md
# i2c_reg_master

Bus-master counterpart of the I2C slave register interface. Executes one register write or one register read per request: START, device address, register pointer, then either a data byte or a repeated START and read of one byte, then STOP. Sits between local control logic and the open-drain SCL/SDA pads; used to drive I2C slaves and for loopback testing of our own slave.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per quarter bit period; minimum 2. One bit slot is 4*CLK_DIV cycles.
- `DEV_ADDR`, default 7'h3c: 7-bit target device address.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `addr` in 8: register pointer, sampled when a request is accepted.
- `dataIn` in 8: write data, sampled when a request is accepted.
- `writeEn` in 1: register write request, accepted only while `busy`=0.
- `readEn` in 1: register read request, accepted only while `busy`=0.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse at the end of a transaction.
- `ackErr` out 1: NACK seen in the last transaction; valid with `done`, held until the next accept.
- `dataOut` out 8: byte read by the last successful read; held.
- `sclOut` out 1: 0 drives SCL low, 1 releases it.
- `sdaOut` out 1: 0 drives SDA low, 1 releases it.
- `sdaIn` in 1: sampled SDA.
- `sclIn` in 1: sampled SCL, used only with clock stretching.

## Operation
- Reset values: `busy`=0, `done`=0, `ackErr`=0, `dataOut`=8'h00, `sclOut`=1, `sdaOut`=1, state IDLE.
- Accept: in IDLE, `writeEn` or `readEn` high at a rising edge latches `addr`/`dataIn`. If both are high, the write wins. Requests while `busy`=1 are ignored and not queued.
- States: IDLE, START, SEND_BYTE, GET_ACK, RSTART, RECV_BYTE, SEND_NACK, STOP.
- Write sequence: START; send {DEV_ADDR,0}, ACK; send `addr`, ACK; send `dataIn`, ACK; STOP.
- Read sequence: START; send {DEV_ADDR,0}, ACK; send `addr`, ACK; RSTART; send {DEV_ADDR,1}, ACK; RECV 8 bits; SEND_NACK (SDA released); STOP.
- Bits are sent and received MSB first.
- Bit slot, quarters q0..q3:
  - SCL is low in q0 and q1, high in q2 and q3.
  - SDA changes only at the start of q0.
  - `sdaIn` is sampled in the last cycle of q2.
- START/RSTART slot: SDA released in q0–q1 and pulled low in q2–q3, with SCL released from q1. RSTART first releases SDA while SCL is low.
- STOP slot: SDA low in q0–q1, SCL released from q1, SDA released in q2–q3.
- NACK: `sdaIn`=1 in any GET_ACK aborts. Go directly to STOP, then set `ackErr`=1 with `done`. `dataOut` is unchanged.
- `dataOut` updates in the same cycle as a successful read's `done`.

## Timing
- Accept at edge N: `busy`=1 from N+1.
- End of transaction: `done`=1 and `busy`=0 in the cycle after the STOP slot's last quarter.
- Write: 29 slots = 116*CLK_DIV cycles from accept to `done`.
- Read: 39 slots = 156*CLK_DIV cycles.
- Address NACK: 11 slots. Pointer NACK: 20 slots.
- A new request is accepted in the same cycle that `done` is high.
- `rst` mid-transaction: the next cycle returns to reset values with both lines released. No STOP is generated, and the target may be left mid-frame.
- Quarter counter: wraps from CLK_DIV-1 to 0. Bit counter: 7 down to 0.

## Configuration
- `I2C_MASTER_CLK_STRETCH_EN` defined: the quarter counter holds in q2 while `sclIn`=0 after SCL is released. The bit slot lengthens by exactly the stretch duration.
- Undefined: `sclIn` is ignored and timing is strictly fixed.

## Test plan
- Write, CLK_DIV=4, `addr`=8'h02, `dataIn`=8'hA5, acking slave model -> bus bytes 0x78, 0x02, 0xA5; `done` 464 cycles after accept; `ackErr`=0.
- Read, `addr`=8'h05, slave returns 8'h5A -> bytes 0x78, 0x05, RSTART, 0x79; master NACK; `dataOut`=8'h5A; 624 cycles.
- No slave present (address NACK) -> STOP after 11 slots; `done` at 176 cycles; `ackErr`=1; `dataOut` unchanged.
- `writeEn` and `readEn` asserted together, then `readEn` pulsed mid-transaction -> write performed; mid-transaction request ignored; exactly one `done`.
- `rst` asserted during the pointer byte -> next cycle `sclOut`=`sdaOut`=1, `busy`=0; a following write completes normally.
- With `I2C_MASTER_CLK_STRETCH_EN`, slave holds SCL low 10 cycles on the first ACK bit -> write `done` at 474 cycles with bytes unchanged.
